// File: rtl/box_engine_pkg.sv
// Shared types for the box engine: box record, sweep FSM state, screen size.
// Axis fields are held at AW bits so one record type serves any pA <= AW.
package box_pkg;

  localparam int AW      = 16;
  localparam int SCR_W_D = 640;
  localparam int SCR_H_D = 480;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [AW-1:0]      x;
    logic [AW-1:0]      y;
    logic [AW-1:0]      w;
    logic [AW-1:0]      h;
    logic signed [3:0]  vx;
    logic signed [3:0]  vy;
    logic [11:0]        color;
    logic               en;
  } box_t;

  typedef struct packed {
    logic [AW-1:0]      p;
    logic signed [3:0]  v;
  } axis_t;

  function automatic logic signed [3:0] vneg(
    input logic signed [3:0] v
  );
    return (v == -4'sd8) ? 4'sd7 : -v;
  endfunction

  // One frame of motion on one axis with bounce at 0 and lim.
  function automatic axis_t axis_step(
    input logic [AW-1:0]     p,
    input logic [AW-1:0]     s,
    input logic signed [3:0] v,
    input int                lim
  );
    logic signed [AW+1:0] n;
    int                   ni;
    axis_t                r;
    n  = $signed({2'b00, p}) + v;
    ni = int'(n);
    r  = '{p: p, v: v};
    if (ni < 0) begin
      r.p = '0;
      r.v = vneg(v);
    end else if (ni + int'(s) > lim) begin
      r.p = AW'(lim - int'(s));
      r.v = vneg(v);
    end else begin
      r.p = n[AW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/box_engine_if.sv
// Pixel, configuration and colour-out bundle of the box engine.
// master = pixel source / configurator, slave = box_engine.
interface box_engine_if #(
  parameter int pA = 10,
  parameter int cA = 4,
  parameter int NB = 4
) ();
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [pA-1:0]      pix_x;
  logic [pA-1:0]      pix_y;
  logic               pix_v;
  logic               frame_tick;
  logic               cfg_we;
  logic [IW-1:0]      cfg_idx;
  logic               cfg_en;
  logic [pA-1:0]      cfg_x;
  logic [pA-1:0]      cfg_y;
  logic [pA-1:0]      cfg_w;
  logic [pA-1:0]      cfg_h;
  logic [3:0]         cfg_vx;
  logic [3:0]         cfg_vy;
  logic [11:0]        cfg_color;
  logic               cfg_ready;
  logic [2:0][cA-1:0] color;
  logic               hit_v;
  logic [IW-1:0]      hit_idx;

  modport master (
    output pix_x, pix_y, pix_v, frame_tick,
    output cfg_we, cfg_idx, cfg_en,
    output cfg_x, cfg_y, cfg_w, cfg_h,
    output cfg_vx, cfg_vy, cfg_color,
    input  cfg_ready, color, hit_v, hit_idx
  );

  modport slave (
    input  pix_x, pix_y, pix_v, frame_tick,
    input  cfg_we, cfg_idx, cfg_en,
    input  cfg_x, cfg_y, cfg_w, cfg_h,
    input  cfg_vx, cfg_vy, cfg_color,
    output cfg_ready, color, hit_v, hit_idx
  );
endinterface

// File: rtl/box_engine_hit.sv
// box_hit: inclusive rectangle coverage test for one box.
// BOX_ENGINE_BORDER_EN restricts coverage to the 1-pixel outline.
module box_hit
  import box_pkg::*;
#(
  parameter int pA = 10
) (
  input  logic [pA-1:0] i_px,
  input  logic [pA-1:0] i_py,
  input  logic [AW-1:0] i_x,
  input  logic [AW-1:0] i_y,
  input  logic [AW-1:0] i_w,
  input  logic [AW-1:0] i_h,
  output logic          o_hit
);
  logic [AW:0] w_px, w_py;
  logic [AW:0] w_x0, w_y0;
  logic [AW:0] w_x1, w_y1;
  logic        w_in;

  assign w_px = (AW+1)'(i_px);
  assign w_py = (AW+1)'(i_py);
  assign w_x0 = (AW+1)'(i_x);
  assign w_y0 = (AW+1)'(i_y);
  assign w_x1 = w_x0 + (AW+1)'(i_w);
  assign w_y1 = w_y0 + (AW+1)'(i_h);

  assign w_in = (w_px >= w_x0) && (w_px <= w_x1)
             && (w_py >= w_y0) && (w_py <= w_y1);

`ifdef BOX_ENGINE_BORDER_EN
  assign o_hit = w_in && ((w_px == w_x0) || (w_px == w_x1)
                       || (w_py == w_y0) || (w_py == w_y1));
`else
  assign o_hit = w_in;
`endif

endmodule

// File: rtl/box_engine.sv
// box_engine: NB bouncing boxes, 2-stage pixel path, per-frame motion sweep.
// Define BOX_ENGINE_BORDER_EN for outline-only boxes.
module box_engine
  import box_pkg::*;
#(
  parameter int pA    = 10,
  parameter int cA    = 4,
  parameter int NB    = 4,
  parameter int SCR_W = SCR_W_D,
  parameter int SCR_H = SCR_H_D
) (
  input logic         clk,
  input logic         rst_n,
  box_engine_if.slave bus
);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t             r_state, w_next;
  logic               w_ready;
  logic [IW-1:0]      r_idx;
  box_t               r_box [NB];
  box_t               w_cfg, w_cur, w_upd;
  axis_t              w_ax, w_ay;
  logic [NB-1:0]      w_hit, r_hit;
  logic               r_v;
  logic               w_any;
  logic [IW-1:0]      w_sel;
  logic [11:0]        w_rgb;
  logic [2:0][cA-1:0] r_col;
  logic               r_hv;
  logic [IW-1:0]      r_hidx;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.frame_tick) w_next = UPDATE;
      end
      UPDATE: begin
        if (r_idx == IW'(NB-1)) w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_cfg       = '0;
    w_cfg.x     = AW'(bus.cfg_x);
    w_cfg.y     = AW'(bus.cfg_y);
    w_cfg.w     = AW'(bus.cfg_w);
    w_cfg.h     = AW'(bus.cfg_h);
    w_cfg.vx    = bus.cfg_vx;
    w_cfg.vy    = bus.cfg_vy;
    w_cfg.color = bus.cfg_color;
    w_cfg.en    = bus.cfg_en;
  end

  always_comb begin
    w_cur = r_box[0];
    for (int k = 1; k < NB; k++)
      if (r_idx == IW'(k)) w_cur = r_box[k];
    w_ax     = axis_step(w_cur.x, w_cur.w, w_cur.vx, SCR_W-1);
    w_ay     = axis_step(w_cur.y, w_cur.h, w_cur.vy, SCR_H-1);
    w_upd    = w_cur;
    w_upd.x  = w_ax.p;
    w_upd.vx = w_ax.v;
    w_upd.y  = w_ay.p;
    w_upd.vy = w_ay.v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int k = 0; k < NB; k++) r_box[k] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == UPDATE)
        r_idx <= (w_next == IDLE) ? '0 : r_idx + IW'(1);
      for (int k = 0; k < NB; k++) begin
        if (w_ready && bus.cfg_we && bus.cfg_idx == IW'(k))
          r_box[k] <= w_cfg;
        else if (r_state == UPDATE && r_idx == IW'(k) && w_cur.en)
          r_box[k] <= w_upd;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_hit
    logic w_h;
    box_hit #(.pA(pA)) u_hit (
      .i_px  (bus.pix_x),
      .i_py  (bus.pix_y),
      .i_x   (r_box[g].x),
      .i_y   (r_box[g].y),
      .i_w   (r_box[g].w),
      .i_h   (r_box[g].h),
      .o_hit (w_h)
    );
    assign w_hit[g] = w_h && r_box[g].en;
  end

  // Walk downwards so the lowest-index hit is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_rgb = '0;
    for (int k = NB-1; k >= 0; k--) begin
      if (r_hit[k]) begin
        w_any = 1'b1;
        w_sel = IW'(k);
        w_rgb = r_box[k].color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit  <= '0;
      r_v    <= 1'b0;
      r_col  <= '0;
      r_hv   <= 1'b0;
      r_hidx <= '0;
    end else begin
      r_hit <= w_hit;
      r_v   <= bus.pix_v;
      if (r_v && w_any) begin
        r_col[0] <= cA'(w_rgb[11:8]);
        r_col[1] <= cA'(w_rgb[7:4]);
        r_col[2] <= cA'(w_rgb[3:0]);
        r_hv     <= 1'b1;
        r_hidx   <= w_sel;
      end else begin
        r_col  <= '0;
        r_hv   <= 1'b0;
        r_hidx <= '0;
      end
    end
  end

  assign bus.cfg_ready = w_ready;
  assign bus.color     = r_col;
  assign bus.hit_v     = r_hv;
  assign bus.hit_idx   = r_hidx;

endmodule

// File: tb/tb_box_engine.sv
// Self-checking bench for box_engine: rectangle/priority model plus directed probes.
// Honours BOX_ENGINE_BORDER_EN the same way the design does.
module tb_box_engine;
  localparam int NB = 4;
  localparam int SW = 640;
  localparam int SH = 480;

  typedef struct packed {
    logic        hv;
    logic [1:0]  idx;
    logic [11:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_on = 1'b0;
  int   tests = 0;
  int   fails = 0;

  box_engine_if #(.pA(10), .cA(4), .NB(NB)) bus ();

  box_engine #(.pA(10), .cA(4), .NB(NB), .SCR_W(SW), .SCR_H(SH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit          men  [NB];
  int          mx   [NB];
  int          my   [NB];
  int          mw   [NB];
  int          mh   [NB];
  int          mvx  [NB];
  int          mvy  [NB];
  logic [11:0] mcol [NB];

  // Output packing is {blue, green, red} with red in the low nibble.
  function automatic logic [11:0] rgb2out(input logic [11:0] c);
    return {c[3:0], c[7:4], c[11:8]};
  endfunction

  function automatic bit covers(input int k, input int x, input int y);
    bit in;
    in = x >= mx[k] && x <= mx[k] + mw[k] && y >= my[k] && y <= my[k] + mh[k];
`ifdef BOX_ENGINE_BORDER_EN
    return in && (x == mx[k] || x == mx[k] + mw[k]
               || y == my[k] || y == my[k] + mh[k]);
`else
    return in;
`endif
  endfunction

  function automatic exp_t model_out(input logic pv, input int x, input int y);
    exp_t e;
    e = '0;
    if (pv)
      for (int k = 0; k < NB; k++)
        if (!e.hv && men[k] && covers(k, x, y)) begin
          e.hv  = 1'b1;
          e.idx = 2'(k);
          e.col = rgb2out(mcol[k]);
        end
    return e;
  endfunction

  task automatic step_axis(inout int p, inout int v, input int s, input int lim);
    int n;
    n = p + v;
    if (n < 0) begin
      p = 0;
      v = (v == -8) ? 7 : -v;
    end else if (n + s > lim) begin
      p = lim - s;
      v = (v == -8) ? 7 : -v;
    end else begin
      p = n;
    end
  endtask

  task automatic model_sweep();
    for (int k = 0; k < NB; k++)
      if (men[k]) begin
        step_axis(mx[k], mvx[k], mw[k], SW - 1);
        step_axis(my[k], mvy[k], mh[k], SH - 1);
      end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      men[k] = 0; mx[k] = 0; my[k] = 0; mw[k] = 0; mh[k] = 0;
      mvx[k] = 0; mvy[k] = 0; mcol[k] = '0;
    end
  endtask

  exp_t e1 = '0;
  exp_t e2 = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      e1 <= '0;
      e2 <= '0;
    end else begin
      e1 <= model_out(bus.pix_v, int'(bus.pix_x), int'(bus.pix_y));
      e2 <= e1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if (bus.hit_v !== e2.hv || bus.hit_idx !== e2.idx || bus.color !== e2.col) begin
        fails++;
        $display("FAIL pixel_cmp t=%0t got hv=%b idx=%0d col=%h want hv=%b idx=%0d col=%h",
                 $time, bus.hit_v, bus.hit_idx, bus.color, e2.hv, e2.idx, e2.col);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic cfg(input int k, input bit en, input int x, input int y,
                     input int w, input int h, input int vx, input int vy,
                     input logic [11:0] c);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'(k); bus.cfg_en = en;
    bus.cfg_x = 10'(x); bus.cfg_y = 10'(y);
    bus.cfg_w = 10'(w); bus.cfg_h = 10'(h);
    bus.cfg_vx = 4'(vx); bus.cfg_vy = 4'(vy); bus.cfg_color = c;
    men[k] = en; mx[k] = x; my[k] = y; mw[k] = w; mh[k] = h;
    mvx[k] = vx; mvy[k] = vy; mcol[k] = c;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic probe(input string nm, input int x, input int y, input bit pv,
                       input bit ehv, input int eidx, input logic [11:0] ecol);
    @(posedge clk); #1;
    bus.pix_x = 10'(x); bus.pix_y = 10'(y); bus.pix_v = pv;
    @(posedge clk); #1;
    bus.pix_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.hit_v !== ehv || bus.hit_idx !== 2'(eidx) || bus.color !== ecol) begin
      fails++;
      $display("FAIL %s: got hv=%b idx=%0d col=%h want hv=%b idx=%0d col=%h",
               nm, bus.hit_v, bus.hit_idx, bus.color, ehv, eidx, ecol);
    end
  endtask

  // Frame tick, then count busy cycles; optional ignored write / extra tick mid-sweep.
  task automatic sweep(input string nm, input bit mid_we, input bit mid_tick);
    int n;
    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    chk({nm, "_ready_low"}, 32'(bus.cfg_ready), 32'd0);
    n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 64) begin
      n++;
      if (n == 1 && mid_we) begin
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_en = 1'b0;
        bus.cfg_x = 10'd1; bus.cfg_y = 10'd1; bus.cfg_color = 12'h123;
      end
      if (n == 2 && mid_tick) bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      bus.frame_tick = 1'b0;
    end
    chk({nm, "_len"}, 32'(n), 32'(NB));
    model_sweep();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pix_x = '0; bus.pix_y = '0; bus.pix_v = 1'b0; bus.frame_tick = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_w = '0; bus.cfg_h = '0;
    bus.cfg_vx = '0; bus.cfg_vy = '0; bus.cfg_color = '0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_hit_v", 32'(bus.hit_v), 32'd0);
    chk("rst_color", 32'(bus.color), 32'd0);
    chk("rst_idx", 32'(bus.hit_idx), 32'd0);

    cfg(0, 1, 10, 10, 5, 5, 0, 0, 12'hF00);
`ifdef BOX_ENGINE_BORDER_EN
    probe("b0_inner", 12, 12, 1, 0, 0, 12'h000);
`else
    probe("b0_inner", 12, 12, 1, 1, 0, 12'h00F);
`endif
    probe("b0_edge", 10, 12, 1, 1, 0, 12'h00F);
    probe("b0_corner", 15, 15, 1, 1, 0, 12'h00F);
    probe("b0_right", 16, 12, 1, 0, 0, 12'h000);
    probe("b0_nopv", 10, 12, 0, 0, 0, 12'h000);

    cfg(0, 1, 15, 15, 10, 10, 0, 0, 12'h0F0);
    cfg(1, 1, 18, 18, 4, 4, 0, 0, 12'h00F);
`ifdef BOX_ENGINE_BORDER_EN
    probe("ovl_20", 20, 20, 1, 0, 0, 12'h000);
    probe("ovl_18", 18, 20, 1, 1, 1, 12'hF00);
`else
    probe("ovl_20", 20, 20, 1, 1, 0, 12'h0F0);
    probe("ovl_18", 18, 20, 1, 1, 0, 12'h0F0);
`endif
    cfg(0, 0, 15, 15, 10, 10, 0, 0, 12'h0F0);
    probe("dis_b0", 18, 20, 1, 1, 1, 12'hF00);

    cfg(0, 1, 635, 100, 4, 4, 3, 0, 12'hFFF);
    cfg(2, 1, 3, 50, 2, 2, -8, 0, 12'hA50);
    cfg(3, 1, 300, 478, 2, 1, 0, 1, 12'h888);
    sweep("sw1", 0, 0);
    probe("r_bounce", 635, 102, 1, 1, 0, 12'hFFF);
    probe("r_left", 634, 102, 1, 0, 0, 12'h000);
    probe("l_bounce", 0, 51, 1, 1, 2, 12'h05A);
    probe("b_bounce", 301, 478, 1, 1, 3, 12'h888);
    sweep("sw2", 1, 1);
    probe("r_move", 632, 102, 1, 1, 0, 12'hFFF);
    probe("r_far", 636, 102, 1, 1, 0, 12'hFFF);
    probe("r_out", 637, 102, 1, 0, 0, 12'h000);
    probe("sat_pos", 7, 51, 1, 1, 2, 12'h05A);
    probe("sat_prev", 6, 51, 1, 0, 0, 12'h000);
    probe("b_move", 301, 477, 1, 1, 3, 12'h888);
    probe("b_gone", 301, 479, 1, 0, 0, 12'h000);

    @(posedge clk); #1 bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_ready", 32'(bus.cfg_ready), 32'd1);
    chk("abort_hit_v", 32'(bus.hit_v), 32'd0);
    chk("abort_color", 32'(bus.color), 32'd0);
    chk("abort_idx", 32'(bus.hit_idx), 32'd0);
    probe("abort_b0", 632, 102, 1, 0, 0, 12'h000);
    probe("abort_b1", 18, 20, 1, 0, 0, 12'h000);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
